pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It consumes the decode-stage load-use stall request, cache and mul/div busy signals, the EX branch redirect and the MEM trap request. It drives per-stage hold/bubble controls to the PC and the IFID/IDEX/EXMem/MemWb registers, plus the PC redirect. A redirect that arrives while a fetch is in flight is parked until the I-cache is ready; performance counters track lost cycles.

Parameters:
ADDR_WIDTH, 32, PC/target address width
CNT_WIDTH, 32, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
DecodeHazard_StallReq  in  1  load-use hazard from decode
Icache_Busy  in  1  fetch in flight / miss
Dcache_Busy  in  1  MEM-stage access not complete
MulDiv_Busy  in  1  EX multi-cycle op not complete
EX_BranchTaken  in  1  EX resolved taken branch/jump
EX_BranchTarget  in  ADDR_WIDTH  branch target
Trap_Req  in  1  MEM-stage exception/interrupt
Trap_Vector  in  ADDR_WIDTH  trap handler address
Perf_Clr  in  1  synchronous clear of counters
PC_Stall  out  1  hold PC
IFID_Stall, IDEX_Stall, EXMem_Stall  out  1 each  hold stage register
IFID_Flush, IDEX_Flush, EXMem_Flush, MemWb_Flush  out  1 each  load bubble
PC_RedirectEn  out  1  load PC_RedirectAddr this cycle
PC_RedirectAddr  out  ADDR_WIDTH  redirect target
Perf_StallCnt, Perf_LdUseCnt, Perf_RedirCnt  out  CNT_WIDTH each  counters

Behaviour:
- Reset (rst_n=0 at posedge): state=RUN, pend_addr=0, all counters=0. While rst_n=0, all Stall=0, all Flush=1, PC_RedirectEn=0.
- All stall/flush/redirect outputs are combinational from the inputs and the registered state (zero latency). Counters and state update at posedge.
- Hold chain:
  - hold_mem = Dcache_Busy
  - hold_ex = hold_mem | MulDiv_Busy
  - hold_id = hold_ex | DecodeHazard_StallReq
  - hold_if = hold_id | Icache_Busy
- br = EX_BranchTaken & ~hold_ex & state==RUN & ~Trap_Req. A branch under hold is not lost: EX is held, so it re-presents next cycle.
- RUN, no trap:
  - EXMem_Stall = hold_mem
  - IDEX_Stall = hold_ex
  - IFID_Stall = hold_id & ~br
  - MemWb_Flush = Dcache_Busy
  - EXMem_Flush = MulDiv_Busy & ~hold_mem
  - IDEX_Flush = br | (DecodeHazard_StallReq & ~hold_ex)
  - IFID_Flush = br | (Icache_Busy & ~hold_id)
  - PC_Stall = hold_if & ~PC_RedirectEn
- Branch redirect in RUN:
  - br & ~Icache_Busy: PC_RedirectEn=1, PC_RedirectAddr=EX_BranchTarget.
  - br & Icache_Busy: PC_RedirectEn=0, PC_Stall=1, pend_addr<=EX_BranchTarget, state<=PEND.
- Trap_Req (any state, highest priority):
  - All four Flush=1, all Stall=0. Trap_Req overrides every busy input; the trapping instruction does not retire.
  - ~Icache_Busy: PC_RedirectEn=1, PC_RedirectAddr=Trap_Vector, state<=RUN.
  - Icache_Busy: pend_addr<=Trap_Vector, state<=PEND. An existing pending branch target is overwritten.
- PEND:
  - PC_Stall=1 and IFID_Flush=1 every cycle, discarding wrong-path fetches. EX_BranchTaken is ignored.
  - Downstream holds (IDEX_Stall, EXMem_Stall, EXMem_Flush, MemWb_Flush) follow the RUN rules. IDEX_Flush = DecodeHazard_StallReq & ~hold_ex.
  - First cycle with Icache_Busy=0 and no trap: PC_RedirectEn=1, PC_RedirectAddr=pend_addr, PC_Stall=0, state<=RUN.
- PC_RedirectAddr = 0 when PC_RedirectEn=0.
- Counters (wrap at 2^CNT_WIDTH; Perf_Clr has priority over increment):
  - Perf_StallCnt +1 each cycle PC_Stall=1.
  - Perf_LdUseCnt +1 each cycle a load-use bubble is inserted (DecodeHazard_StallReq & ~hold_ex & ~br & ~Trap_Req).
  - Perf_RedirCnt +1 per accepted redirect event: br or Trap_Req on capture, not at PEND release.
- Reset mid-PEND: state returns to RUN and the pending target is discarded.

Test Plan:
- Load-use: DecodeHazard_StallReq=1 for 1 cycle, others 0 -> PC_Stall=1, IFID_Stall=1, IDEX_Flush=1, IDEX_Stall=0; Perf_LdUseCnt 0->1.
- Dcache miss 3 cycles with DecodeHazard_StallReq=1 -> PC/IFID/IDEX/EXMem_Stall=1 and MemWb_Flush=1 for 3 cycles; IDEX_Flush=0; Perf_LdUseCnt unchanged; Perf_StallCnt=3.
- Branch EX_BranchTarget=0x80000100, Icache_Busy=0 -> same cycle PC_RedirectEn=1, addr=0x80000100, IFID_Flush=IDEX_Flush=1, PC_Stall=0; Perf_RedirCnt=1.
- Branch with Icache_Busy=1 for 2 more cycles -> state PEND, PC_Stall=1 and IFID_Flush=1 for 2 cycles, then 1 cycle PC_RedirectEn=1 addr=0x80000100.
- Trap_Vector=0x00000040 during PEND with pend=0x80000100 -> all Flush=1; release redirect addr=0x00000040; Perf_RedirCnt=2.
- Branch while MulDiv_Busy=1 for 4 cycles -> no redirect, EXMem_Flush=1 for 4 cycles; redirect on the 5th cycle. Counter preset to 2^CNT_WIDTH-1 plus one stall cycle -> 0. Perf_Clr together with a stall cycle -> 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline.
// Parks a redirect while a fetch is in flight and counts lost cycles.
module pipeline_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  DecodeHazard_StallReq,
    input  logic                  Icache_Busy,
    input  logic                  Dcache_Busy,
    input  logic                  MulDiv_Busy,
    input  logic                  EX_BranchTaken,
    input  logic [ADDR_WIDTH-1:0] EX_BranchTarget,
    input  logic                  Trap_Req,
    input  logic [ADDR_WIDTH-1:0] Trap_Vector,
    input  logic                  Perf_Clr,
    output logic                  PC_Stall,
    output logic                  IFID_Stall,
    output logic                  IDEX_Stall,
    output logic                  EXMem_Stall,
    output logic                  IFID_Flush,
    output logic                  IDEX_Flush,
    output logic                  EXMem_Flush,
    output logic                  MemWb_Flush,
    output logic                  PC_RedirectEn,
    output logic [ADDR_WIDTH-1:0] PC_RedirectAddr,
    output logic [CNT_WIDTH-1:0]  Perf_StallCnt,
    output logic [CNT_WIDTH-1:0]  Perf_LdUseCnt,
    output logic [CNT_WIDTH-1:0]  Perf_RedirCnt
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } stateT;

    stateT                 stateReg, stateNext;
    logic [ADDR_WIDTH-1:0] pendAddrReg, pendAddrNext;

    logic holdMem, holdEx, holdId, holdIf;
    logic inRun, br;
    logic [2:0] cntInc;

    // Each stage holds whenever anything downstream of it holds.
    assign holdMem = Dcache_Busy;
    assign holdEx  = holdMem | MulDiv_Busy;
    assign holdId  = holdEx | DecodeHazard_StallReq;
    assign holdIf  = holdId | Icache_Busy;

    assign inRun = (stateReg == RUN);
    // A held branch is not lost: EX keeps presenting it until released.
    assign br    = EX_BranchTaken & ~holdEx & inRun & ~Trap_Req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg    <= RUN;
            pendAddrReg <= '0;
        end else begin
            stateReg    <= stateNext;
            pendAddrReg <= pendAddrNext;
        end
    end

    always_comb begin
        PC_Stall        = 1'b0;
        IFID_Stall      = 1'b0;
        IDEX_Stall      = 1'b0;
        EXMem_Stall     = 1'b0;
        IFID_Flush      = 1'b0;
        IDEX_Flush      = 1'b0;
        EXMem_Flush     = 1'b0;
        MemWb_Flush     = 1'b0;
        PC_RedirectEn   = 1'b0;
        PC_RedirectAddr = '0;
        stateNext       = stateReg;
        pendAddrNext    = pendAddrReg;

        if (!rst_n) begin
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMem_Flush = 1'b1;
            MemWb_Flush = 1'b1;
        end else if (Trap_Req) begin
            // Trap squashes everything, including the trapping instruction.
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMem_Flush = 1'b1;
            MemWb_Flush = 1'b1;
            if (Icache_Busy) begin
                pendAddrNext = Trap_Vector;
                stateNext    = PEND;
            end else begin
                PC_RedirectEn   = 1'b1;
                PC_RedirectAddr = Trap_Vector;
                stateNext       = RUN;
            end
        end else begin
            EXMem_Stall = holdMem;
            IDEX_Stall  = holdEx;
            MemWb_Flush = Dcache_Busy;
            EXMem_Flush = MulDiv_Busy & ~holdMem;
            if (inRun) begin
                IFID_Stall = holdId & ~br;
                IDEX_Flush = br | (DecodeHazard_StallReq & ~holdEx);
                IFID_Flush = br | (Icache_Busy & ~holdId);
                if (br && !Icache_Busy) begin
                    PC_RedirectEn   = 1'b1;
                    PC_RedirectAddr = EX_BranchTarget;
                end else if (br) begin
                    pendAddrNext = EX_BranchTarget;
                    stateNext    = PEND;
                end
                PC_Stall = holdIf & ~PC_RedirectEn;
            end else begin
                // Wrong-path fetches are discarded until the parked target issues.
                IDEX_Flush = DecodeHazard_StallReq & ~holdEx;
                IFID_Flush = 1'b1;
                if (Icache_Busy) begin
                    PC_Stall = 1'b1;
                end else begin
                    PC_RedirectEn   = 1'b1;
                    PC_RedirectAddr = pendAddrReg;
                    stateNext       = RUN;
                end
            end
        end
    end

    // Redirects count on capture only, never at release from PEND.
    assign cntInc[0] = PC_Stall;
    assign cntInc[1] = DecodeHazard_StallReq & ~holdEx & ~br & ~Trap_Req;
    assign cntInc[2] = br | Trap_Req;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gCnt
            logic [CNT_WIDTH-1:0] cntReg;
            always_ff @(posedge clk) begin
                if (!rst_n || Perf_Clr) begin
                    cntReg <= '0;
                end else if (cntInc[gi]) begin
                    cntReg <= cntReg + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    assign Perf_StallCnt = gCnt[0].cntReg;
    assign Perf_LdUseCnt = gCnt[1].cntReg;
    assign Perf_RedirCnt = gCnt[2].cntReg;

endmodule
